// File: rtl/booth_mul_seq_pkg.sv
// mul_pkg: shared types and helpers for the radix-4 Booth multiplier.
//   mul_op_e    : operation select (low half, or one of three high-half flavours)
//   mul_state_e : sequencer states
//   iter_count  : number of Booth digits retired for a WIDTH-bit operand
//   WORD_ITER   : digit count for a 32-bit word operation (BOOTH_MUL_WORD_EN)
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Operands are extended by two bits so unsigned values stay positive;
  // each radix-4 digit covers two of those WIDTH+2 bits.
  function automatic int iter_count(input int width);
    return (width + 2) / 2;
  endfunction

  // 32-bit operands sign/zero-extend past bit 33, so 17 digits suffice.
  localparam int WORD_ITER = 17;

endpackage

// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: request/result handshake bundle for booth_mul_seq.
//   master : issue side (drives request, flush and result-accept)
//   slave  : the multiplier
// Signals: i_valid/o_ready request handshake, i_src1/i_src2/i_op operands,
//          i_flush abort, o_valid/i_ready result handshake, o_result product half.
// Optional macro BOOTH_MUL_WORD_EN adds i_word (32-bit word operation).
interface booth_mul_seq_if #(parameter int WIDTH = 64);
  import mul_pkg::*;

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_src1;
  logic [WIDTH-1:0] i_src2;
  mul_op_e          i_op;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
`ifdef BOOTH_MUL_WORD_EN
  logic             i_word;

  modport master (output i_valid, i_src1, i_src2, i_op, i_flush, i_ready, i_word,
                  input  o_ready, o_valid, o_result);
  modport slave  (input  i_valid, i_src1, i_src2, i_op, i_flush, i_ready, i_word,
                  output o_ready, o_valid, o_result);
`else
  modport master (output i_valid, i_src1, i_src2, i_op, i_flush, i_ready,
                  input  o_ready, o_valid, o_result);
  modport slave  (input  i_valid, i_src1, i_src2, i_op, i_flush, i_ready,
                  output o_ready, o_valid, o_result);
`endif

endinterface

// File: rtl/booth_mul_seq_booth_sel.sv
// booth_sel: radix-4 Booth digit decoder.
//   x : W-bit signed multiplicand
//   s : three overlapping multiplier bits {b(2i+1), b(2i), b(2i-1)}
//   p : W+1-bit partial product (0, +X, +2X, or one's complement of X/2X)
//   c : +1 correction that completes the two's complement negation
module booth_sel #(
  parameter int W = 66
) (
  input  logic [W-1:0] x,
  input  logic [2:0]   s,
  output logic [W:0]   p,
  output logic         c
);

  logic [W:0] x1;
  logic [W:0] x2;

  // Negation is split into ~value here plus a carry injected by the
  // accumulator, which avoids a second adder in the decode path.
  always_comb begin
    x1 = {x[W-1], x};
    x2 = {x, 1'b0};
    p  = '0;
    c  = 1'b0;
    case (s)
      3'b001, 3'b010: p = x1;
      3'b011:         p = x2;
      3'b100:         begin p = ~x2; c = 1'b1; end
      3'b101, 3'b110: begin p = ~x1; c = 1'b1; end
      default:        p = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier, one digit per cycle.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : booth_mul_seq_if.slave (request, flush, result handshake)
// A request is accepted in IDLE, runs ITER=(WIDTH+2)/2 BUSY cycles, then the
// selected product half is held in DONE until the consumer takes it.
// Optional macro BOOTH_MUL_WORD_EN: i_word=1 multiplies the low 32 bits and
// returns the sign-extended low 32 bits of the product after 17 cycles.
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  booth_mul_seq_if.slave bus
);

  localparam int XW   = WIDTH + 2;
  localparam int ACCW = 2 * XW;
  localparam int ITER = iter_count(WIDTH);
  localparam int CW   = $clog2(ITER + 1);

  mul_state_e       state;
  mul_op_e          op;
  logic             word;
  logic [XW-1:0]    mcand;
  logic [XW:0]      mplier;
  logic [ACCW-1:0]  acc;
  logic [CW-1:0]    count;
  logic             valid_q;
  logic [WIDTH-1:0] result_q;

  logic [XW-1:0]    ext1;
  logic [XW-1:0]    ext2;
  logic             s1_signed;
  logic             s2_signed;
  logic [XW:0]      pp;
  logic             pp_c;
  logic [CW:0]      shamt;
  logic [ACCW-1:0]  acc_next;
  logic [CW-1:0]    last_idx;
  logic [WIDTH-1:0] res_sel;

  assign bus.o_ready  = (state == IDLE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;

  // Operand extension at accept. MUL's low half is the same for any
  // signedness, so it simply uses the signed path.
  always_comb begin
    s1_signed = (bus.i_op != MULHU);
    s2_signed = (bus.i_op == MUL) || (bus.i_op == MULH);
    ext1 = s1_signed ? {{2{bus.i_src1[WIDTH-1]}}, bus.i_src1} : {2'b00, bus.i_src1};
    ext2 = s2_signed ? {{2{bus.i_src2[WIDTH-1]}}, bus.i_src2} : {2'b00, bus.i_src2};
`ifdef BOOTH_MUL_WORD_EN
    if (bus.i_word) begin
      ext1 = s1_signed ? {{(XW-32){bus.i_src1[31]}}, bus.i_src1[31:0]}
                       : {{(XW-32){1'b0}}, bus.i_src1[31:0]};
      ext2 = s2_signed ? {{(XW-32){bus.i_src2[31]}}, bus.i_src2[31:0]}
                       : {{(XW-32){1'b0}}, bus.i_src2[31:0]};
    end
`endif
  end

  booth_sel #(.W(XW)) u_booth_sel (
    .x (mcand),
    .s (mplier[2:0]),
    .p (pp),
    .c (pp_c)
  );

  // Digit i weighs 4^i: sign-extend the partial product to the full
  // accumulator width and place it (and its negate carry) at bit 2*count.
  always_comb begin
    shamt    = {count, 1'b0};
    acc_next = acc
             + ({{(ACCW-XW-1){pp[XW]}}, pp} << shamt)
             + (ACCW'(pp_c) << shamt);
    last_idx = word ? CW'(WORD_ITER - 1) : CW'(ITER - 1);
    res_sel  = (op == MUL) ? acc_next[WIDTH-1:0] : acc_next[2*WIDTH-1:WIDTH];
`ifdef BOOTH_MUL_WORD_EN
    if (word) res_sel = {{(WIDTH-32){acc_next[31]}}, acc_next[31:0]};
`endif
  end

  // Sequencer and datapath registers. Flush wins over accept and over
  // retirement; the result register is loaded on the final BUSY step so
  // it is stable for the whole DONE phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      op       <= MUL;
      word     <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (bus.i_flush) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            state  <= BUSY;
            mcand  <= ext1;
            mplier <= {ext2, 1'b0};
            acc    <= '0;
            count  <= '0;
            op     <= bus.i_op;
`ifdef BOOTH_MUL_WORD_EN
            word   <= bus.i_word;
`else
            word   <= 1'b0;
`endif
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier >> 2;
          count  <= count + 1'b1;
          if (count == last_idx) begin
            state    <= DONE;
            valid_q  <= 1'b1;
            result_q <= res_sel;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed self-checking bench for booth_mul_seq (WIDTH=64).
// Covers reset values, all four ops with hand-computed products, result
// latency, result hold under back-pressure, flush, async reset mid-operation
// and, when BOOTH_MUL_WORD_EN is defined, the 32-bit word mode.
module tb_booth_mul_seq;
  import mul_pkg::*;

  localparam int WIDTH = 64;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  booth_mul_seq_if #(.WIDTH(WIDTH)) mif ();

  booth_mul_seq #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and wait (bounded) for the result;
  // returns the product half and the cycles from accept to o_valid.
  task automatic run_op(input mul_op_e op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int cyc);
    mif.i_op    = op;
    mif.i_src1  = a;
    mif.i_src2  = b;
    mif.i_valid = 1'b1;
    tick();
    mif.i_valid = 1'b0;
    cyc = 0;
    while (!mif.o_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    res = mif.o_result;
  endtask

  task automatic retire();
    mif.i_ready = 1'b1;
    tick();
    mif.i_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] res;
    int          cyc;
    int          seen;

    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    mif.i_valid  = 1'b0;
    mif.i_src1   = '0;
    mif.i_src2   = '0;
    mif.i_op     = MUL;
    mif.i_flush  = 1'b0;
    mif.i_ready  = 1'b0;
`ifdef BOOTH_MUL_WORD_EN
    mif.i_word   = 1'b0;
`endif
    #12;
    check("reset_ready",  64'(mif.o_ready),  64'd1);
    check("reset_valid",  64'(mif.o_valid),  64'd0);
    check("reset_result", mif.o_result,      64'd0);
    rst_n = 1'b1;
    tick();

    run_op(MUL, 64'd3, 64'd5, res, cyc);
    check("mul_3x5", res, 64'd15);
    check("mul_latency", 64'(cyc), 64'd33);
    check("done_not_ready", 64'(mif.o_ready), 64'd0);
    retire();
    check("ready_after_retire", 64'(mif.o_ready), 64'd1);

    run_op(MULH, '1, '1, res, cyc);
    check("mulh_m1xm1", res, 64'd0);
    retire();
    run_op(MUL, '1, '1, res, cyc);
    check("mul_m1xm1", res, 64'd1);
    retire();
    run_op(MULHU, '1, '1, res, cyc);
    check("mulhu_ones", res, 64'hFFFF_FFFF_FFFF_FFFE);
    retire();
    run_op(MULHSU, '1, 64'd2, res, cyc);
    check("mulhsu_m1x2", res, 64'hFFFF_FFFF_FFFF_FFFF);
    retire();
    run_op(MULH, 64'h8000_0000_0000_0000, 64'd2, res, cyc);
    check("mulh_min_x2", res, 64'hFFFF_FFFF_FFFF_FFFF);
    retire();
    run_op(MULHU, 64'h8000_0000_0000_0000, 64'd4, res, cyc);
    check("mulhu_2p63x4", res, 64'd2);
    retire();
    run_op(MUL, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6, res, cyc);
    check("mul_m7x6", res, 64'hFFFF_FFFF_FFFF_FFD6);
    retire();

    // Back-pressure: result and o_ready must hold while i_ready is low.
    run_op(MUL, 64'd3, 64'd5, res, cyc);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_result", mif.o_result, 64'd15);
      check("hold_not_ready", 64'(mif.o_ready), 64'd0);
      check("hold_valid", 64'(mif.o_valid), 64'd1);
    end
    retire();
    check("ready_after_hold", 64'(mif.o_ready), 64'd1);
    run_op(MULHU, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, res, cyc);
    check("accept_after_retire", res, 64'd1);
    check("accept_latency", 64'(cyc), 64'd33);
    retire();

    // Flush at BUSY cycle 10: no result ever appears.
    mif.i_op    = MUL;
    mif.i_src1  = 64'd9;
    mif.i_src2  = 64'd9;
    mif.i_valid = 1'b1;
    tick();
    mif.i_valid = 1'b0;
    repeat (9) tick();
    mif.i_flush = 1'b1;
    tick();
    mif.i_flush = 1'b0;
    check("flush_ready", 64'(mif.o_ready), 64'd1);
    check("flush_valid", 64'(mif.o_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mif.o_valid) seen++;
    end
    check("flush_no_valid", 64'(seen), 64'd0);

    // Request together with flush is dropped.
    mif.i_valid = 1'b1;
    mif.i_flush = 1'b1;
    tick();
    mif.i_valid = 1'b0;
    mif.i_flush = 1'b0;
    check("flush_drops_req", 64'(mif.o_ready), 64'd1);

    // Async reset mid-BUSY after a result left o_result nonzero.
    run_op(MUL, 64'd6, 64'd7, res, cyc);
    check("mul_6x7", res, 64'd42);
    retire();
    mif.i_src1  = 64'd11;
    mif.i_src2  = 64'd13;
    mif.i_valid = 1'b1;
    tick();
    mif.i_valid = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready",  64'(mif.o_ready), 64'd1);
    check("arst_valid",  64'(mif.o_valid), 64'd0);
    check("arst_result", mif.o_result,     64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(MUL, 64'd11, 64'd13, res, cyc);
    check("mul_after_reset", res, 64'd143);
    retire();

`ifdef BOOTH_MUL_WORD_EN
    mif.i_word = 1'b1;
    run_op(MUL, 64'h0000_0000_7FFF_FFFF, 64'd2, res, cyc);
    check("word_mul", res, 64'hFFFF_FFFF_FFFF_FFFE);
    check("word_latency", 64'(cyc), 64'd17);
    retire();
    mif.i_word = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
